// File: rtl/sasanqua_axi_pkg.sv
// AXI4 constants and fetch FSM encoding shared by the instruction fetch unit.
package sasanqua_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_ADDR  = 2'd1,
    FETCH_DATA  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_t;

  // Words in the burst: capped so a burst never crosses a 4 KB page.
  function automatic logic [4:0] burst_words(
    input logic [9:0]  word_idx,
    input int unsigned blen
  );
    logic [10:0] left;
    left = 11'd1024 - {1'b0, word_idx};
    if (left < 11'(blen)) return left[4:0];
    return 5'(blen);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for fetched instruction entries.
// Flush beats push and pop; the head is read combinationally.
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_rdata,
  output logic          o_valid,
  output logic [AW:0]   o_free
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !i_flush && (r_cnt != AW'(0) + (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !i_flush && (r_cnt != '0);
  assign o_valid = (r_cnt != '0);
  assign o_rdata = r_mem[r_rp];
  assign o_free  = (AW+1)'(DEPTH) - r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_axi.sv
// AXI4 instruction prefetcher feeding the core fetch stage.
// Define FETCH_RRESP_CHECK_EN to flag error beats and halt issue until a redirect.
module inst_fetch_axi
  import sasanqua_axi_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 32,
  parameter int BURST_LEN        = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter logic [C_OFFSET_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        JUMP_VALID,
  input  logic [C_OFFSET_WIDTH-1:0]   JUMP_PC,
  output logic                        INST_VALID,
  input  logic                        INST_READY,
  output logic [C_OFFSET_WIDTH-1:0]   INST_PC,
  output logic [31:0]                 INST_DATA,
  output logic                        INST_ERR,
  output logic [C_OFFSET_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int PW = C_OFFSET_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int FA = $clog2(FIFO_DEPTH);
`ifdef FETCH_RRESP_CHECK_EN
  localparam int EW = 1 + PW + DW;
`else
  localparam int EW = PW + DW;
`endif

  fetch_state_t  r_state;
  fetch_state_t  w_next;
  logic [PW-1:0] r_pc;
  logic [PW-1:0] r_araddr;
  logic [7:0]    r_arlen;
  logic          r_jmp_pend;
  logic          w_beat;
  logic          w_push;
  logic          w_room;
  logic          w_hold;
  logic [4:0]    w_blen;
  logic [PW-1:0] w_jpc;
  logic [FA:0]   w_free;
  logic [EW-1:0] w_went;
  logic [EW-1:0] w_rent;
  logic          w_unused;

  assign w_beat = M_AXI_RVALID && M_AXI_RREADY;
  assign w_push = (r_state == FETCH_DATA) && w_beat && !JUMP_VALID;
  assign w_jpc  = {JUMP_PC[PW-1:2], 2'b00};
  assign w_blen = burst_words(r_pc[11:2], BURST_LEN);
  assign w_room = 32'(w_free) >= 32'(w_blen);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= FETCH_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FETCH_IDLE:
        if (w_room && !JUMP_VALID && !w_hold) w_next = FETCH_ADDR;
      FETCH_ADDR:
        if (M_AXI_ARREADY)
          w_next = (r_jmp_pend || JUMP_VALID) ? FETCH_DRAIN : FETCH_DATA;
      FETCH_DATA:
        if (w_beat && M_AXI_RLAST) w_next = FETCH_IDLE;
        else if (JUMP_VALID)       w_next = FETCH_DRAIN;
      FETCH_DRAIN:
        if (w_beat && M_AXI_RLAST) w_next = FETCH_IDLE;
      default: w_next = FETCH_IDLE;
    endcase
  end

  always_comb begin
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    unique case (1'b1)
      (r_state == FETCH_ADDR):  M_AXI_ARVALID = 1'b1;
      (r_state == FETCH_DATA),
      (r_state == FETCH_DRAIN): M_AXI_RREADY  = 1'b1;
      default: ;
    endcase
  end

  // A redirect seen while AR is pending must still drain that burst.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc       <= RESET_PC;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_jmp_pend <= 1'b0;
    end else begin
      if (r_state == FETCH_IDLE && w_next == FETCH_ADDR) begin
        r_araddr <= r_pc;
        r_arlen  <= 8'(w_blen - 5'd1);
      end
      if (JUMP_VALID)  r_pc <= w_jpc;
      else if (w_push) r_pc <= r_pc + PW'(4);
      r_jmp_pend <= (r_state == FETCH_ADDR) && !M_AXI_ARREADY &&
                    (r_jmp_pend || JUMP_VALID);
    end
  end

  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARLEN   = r_arlen;
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;

`ifdef FETCH_RRESP_CHECK_EN
  logic r_err_hold;
  logic w_rerr;
  assign w_rerr = (M_AXI_RRESP != AXI_RESP_OKAY);
  assign w_hold = r_err_hold;
  assign w_went = {w_rerr, r_pc, M_AXI_RDATA};
  assign INST_ERR = w_rent[EW-1];
  assign w_unused = &{1'b0, JUMP_PC[1:0]};

  always_ff @(posedge CLK) begin
    if (RST || JUMP_VALID)    r_err_hold <= 1'b0;
    else if (w_push && w_rerr) r_err_hold <= 1'b1;
  end
`else
  assign w_hold   = 1'b0;
  assign w_went   = {r_pc, M_AXI_RDATA};
  assign INST_ERR = 1'b0;
  assign w_unused = &{1'b0, JUMP_PC[1:0], M_AXI_RRESP};
`endif

  assign INST_PC   = w_rent[DW +: PW];
  assign INST_DATA = w_rent[31:0];

  fetch_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_wdata (w_went),
    .i_pop   (INST_VALID && INST_READY),
    .i_flush (JUMP_VALID),
    .o_rdata (w_rent),
    .o_valid (INST_VALID),
    .o_free  (w_free)
  );

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Bench for inst_fetch_axi with an AXI read slave model over RAM word i = 0x1000_0000+i.
module tb_inst_fetch_axi;

  logic        CLK;
  logic        RST;
  logic        JUMP_VALID;
  logic [31:0] JUMP_PC;
  logic        INST_VALID;
  logic        INST_READY;
  logic [31:0] INST_PC;
  logic [31:0] INST_DATA;
  logic        INST_ERR;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  inst_fetch_axi dut (
    .CLK           (CLK),
    .RST           (RST),
    .JUMP_VALID    (JUMP_VALID),
    .JUMP_PC       (JUMP_PC),
    .INST_VALID    (INST_VALID),
    .INST_READY    (INST_READY),
    .INST_PC       (INST_PC),
    .INST_DATA     (INST_DATA),
    .INST_ERR      (INST_ERR),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_ARSIZE  (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  int          ar_cnt = 0;
  int          ar_delay = 0;
  int          err_beat = -1;
  int          wcnt;
  int          bidx;
  logic        bbusy;
  logic [31:0] baddr;
  logic [7:0]  bleft;
  logic [31:0] last_addr;
  logic [7:0]  last_len;

  function automatic logic [31:0] ram(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  function automatic logic [1:0] resp(input int i);
    return (i == err_beat) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      M_AXI_ARREADY <= 1'b0;
      M_AXI_RVALID  <= 1'b0;
      M_AXI_RLAST   <= 1'b0;
      M_AXI_RRESP   <= 2'b00;
      M_AXI_RDATA   <= '0;
      bbusy <= 1'b0;
      wcnt  <= 0;
      bidx  <= 0;
    end else begin
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_ARREADY <= 1'b0;
        wcnt  <= 0;
        bbusy <= 1'b1;
        baddr <= M_AXI_ARADDR;
        bleft <= M_AXI_ARLEN;
        bidx  <= 0;
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= ram(M_AXI_ARADDR);
        M_AXI_RLAST  <= (M_AXI_ARLEN == 8'd0);
        M_AXI_RRESP  <= resp(0);
        ar_cnt    <= ar_cnt + 1;
        last_addr <= M_AXI_ARADDR;
        last_len  <= M_AXI_ARLEN;
      end else if (M_AXI_ARVALID && !bbusy) begin
        if (wcnt >= ar_delay) M_AXI_ARREADY <= 1'b1;
        else wcnt <= wcnt + 1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        if (M_AXI_RLAST) begin
          M_AXI_RVALID <= 1'b0;
          M_AXI_RLAST  <= 1'b0;
          bbusy <= 1'b0;
        end else begin
          baddr <= baddr + 32'd4;
          bleft <= bleft - 8'd1;
          bidx  <= bidx + 1;
          M_AXI_RDATA <= ram(baddr + 32'd4);
          M_AXI_RLAST <= (bleft == 8'd1);
          M_AXI_RRESP <= resp(bidx + 1);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_ar(input int n, input string nm);
    int t = 0;
    while (ar_cnt < n && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk({nm, "_ar_timeout"}, 32'(ar_cnt >= n), 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    while (!INST_VALID && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk({nm, "_valid_timeout"}, 32'(INST_VALID), 32'd1);
  endtask

  task automatic wait_arvalid(input string nm);
    int t = 0;
    while (!M_AXI_ARVALID && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk({nm, "_arvalid_timeout"}, 32'(M_AXI_ARVALID), 32'd1);
  endtask

  task automatic do_reset(input int dly, input int eb, input logic rdy);
    @(negedge CLK);
    RST = 1'b1;
    JUMP_VALID = 1'b0;
    INST_READY = rdy;
    ar_delay = dly;
    err_beat = eb;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic jump(input logic [31:0] pc);
    JUMP_PC = pc;
    JUMP_VALID = 1'b1;
    @(negedge CLK);
    JUMP_VALID = 1'b0;
  endtask

  task automatic pop_seq(input string nm, input logic [31:0] pc0,
                         input int n);
    for (int i = 0; i < n; i++) begin
      wait_valid(nm);
      chk({nm, "_pc"}, INST_PC, pc0 + 32'(4 * i));
      chk({nm, "_data"}, INST_DATA, ram(pc0 + 32'(4 * i)));
      @(negedge CLK);
    end
  endtask

  typedef struct {
    logic [31:0] jpc;
    logic [31:0] a1;
    logic [7:0]  l1;
    logic [31:0] a2;
    logic [7:0]  l2;
    logic [31:0] pc;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0;
    int t;
    int stable;
    logic [31:0] a;

    vecs[0] = '{32'h0000_0102, 32'h0000_0100, 8'd7, 32'h0000_0120, 8'd7,
                32'h0000_0100, 32'h1000_0040};
    vecs[1] = '{32'h0000_0FF8, 32'h0000_0FF8, 8'd1, 32'h0000_1000, 8'd7,
                32'h0000_0FF8, 32'h1000_03FE};
    vecs[2] = '{32'h0000_0FFC, 32'h0000_0FFC, 8'd0, 32'h0000_1000, 8'd7,
                32'h0000_0FFC, 32'h1000_03FF};
    vecs[3] = '{32'h0000_2000, 32'h0000_2000, 8'd7, 32'h0000_2020, 8'd7,
                32'h0000_2000, 32'h1000_0800};
    vecs[4] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 8'd3, 32'h0000_0000, 8'd7,
                32'hFFFF_FFF0, 32'h4FFF_FFFC};
    vecs[5] = '{32'h0000_0007, 32'h0000_0004, 8'd7, 32'h0000_0024, 8'd7,
                32'h0000_0004, 32'h1000_0001};
    vecs[6] = '{32'h0000_0FE0, 32'h0000_0FE0, 8'd7, 32'h0000_1000, 8'd7,
                32'h0000_0FE0, 32'h1000_03F8};

    RST = 1'b1;
    JUMP_VALID = 1'b0;
    JUMP_PC = '0;
    INST_READY = 1'b0;

    // Reset state, first burst, and first-beat latency.
    @(negedge CLK);
    RST = 1'b1;
    INST_READY = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_inst_valid", 32'(INST_VALID), 32'd0);
    chk("rst_inst_err", 32'(INST_ERR), 32'd0);
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("rst_rready", 32'(M_AXI_RREADY), 32'd0);
    chk("rst_araddr", M_AXI_ARADDR, 32'h0);
    RST = 1'b0;
    n0 = ar_cnt;
    t = 0;
    while (!(M_AXI_RVALID && M_AXI_RREADY) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk("t1_beat_timeout", 32'(M_AXI_RVALID && M_AXI_RREADY), 32'd1);
    chk("t1_lat_pre", 32'(INST_VALID), 32'd0);
    chk("t1_ar_cnt", 32'(ar_cnt - n0), 32'd1);
    chk("t1_araddr", last_addr, 32'h0);
    chk("t1_arlen", 32'(last_len), 32'd7);
    chk("t1_arsize", 32'(M_AXI_ARSIZE), 32'd2);
    chk("t1_arburst", 32'(M_AXI_ARBURST), 32'd1);
    @(negedge CLK);
    chk("t1_lat_post", 32'(INST_VALID), 32'd1);
    pop_seq("t1", 32'h0, 8);

    // Consumer stalled: two bursts fill the FIFO, then issue stops.
    do_reset(0, -1, 1'b0);
    n0 = ar_cnt;
    repeat (100) @(negedge CLK);
    chk("t2_ar_cnt", 32'(ar_cnt - n0), 32'd2);
    chk("t2_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("t2_last_addr", last_addr, 32'h20);
    INST_READY = 1'b1;
    pop_seq("t2", 32'h0, 16);

    // Redirect during beat 3 of the first burst.
    do_reset(0, -1, 1'b1);
    t = 0;
    while (!(M_AXI_RVALID && M_AXI_RREADY && bidx == 3) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk("t3_beat3_timeout", 32'(bidx), 32'd3);
    n0 = ar_cnt;
    jump(32'h102);
    wait_ar(n0 + 1, "t3");
    chk("t3_araddr", last_addr, 32'h100);
    pop_seq("t3", 32'h100, 8);

    // Redirect table applied with the FIFO full and the FSM idle.
    do_reset(0, -1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      repeat (40) @(negedge CLK);
      n0 = ar_cnt;
      jump(vecs[i].jpc);
      wait_ar(n0 + 1, "tv");
      chk($sformatf("tv%0d_a1", i), last_addr, vecs[i].a1);
      chk($sformatf("tv%0d_l1", i), 32'(last_len), 32'(vecs[i].l1));
      wait_valid("tv");
      chk($sformatf("tv%0d_pc", i), INST_PC, vecs[i].pc);
      chk($sformatf("tv%0d_data", i), INST_DATA, vecs[i].data);
      wait_ar(n0 + 2, "tv");
      chk($sformatf("tv%0d_a2", i), last_addr, vecs[i].a2);
      chk($sformatf("tv%0d_l2", i), 32'(last_len), 32'(vecs[i].l2));
    end

    // Slow ARREADY: address phase must hold steady.
    do_reset(5, -1, 1'b1);
    wait_arvalid("t5a");
    a = M_AXI_ARADDR;
    stable = 1;
    t = 0;
    while (!M_AXI_ARREADY && t < 50) begin
      @(negedge CLK);
      if (!M_AXI_ARVALID || M_AXI_ARADDR != a) stable = 0;
      t++;
    end
    chk("t5a_stable", 32'(stable), 32'd1);
    chk("t5a_wait_ge5", 32'(t >= 5), 32'd1);

    // Redirect while AR is pending: AR completes, burst is drained.
    do_reset(5, -1, 1'b1);
    n0 = ar_cnt;
    wait_arvalid("t5b");
    a = M_AXI_ARADDR;
    repeat (2) @(negedge CLK);
    jump(32'h400);
    stable = 1;
    t = 0;
    while (!M_AXI_ARREADY && t < 50) begin
      if (!M_AXI_ARVALID || M_AXI_ARADDR != a) stable = 0;
      @(negedge CLK);
      t++;
    end
    chk("t5b_stable", 32'(stable), 32'd1);
    wait_ar(n0 + 1, "t5b");
    chk("t5b_old_addr", last_addr, 32'h0);
    wait_ar(n0 + 2, "t5b");
    chk("t5b_new_addr", last_addr, 32'h400);
    pop_seq("t5b", 32'h400, 4);

`ifdef FETCH_RRESP_CHECK_EN
    // Error beat is flagged and issue halts until a redirect.
    do_reset(0, 2, 1'b0);
    n0 = ar_cnt;
    repeat (60) @(negedge CLK);
    chk("t6_ar_halt", 32'(ar_cnt - n0), 32'd1);
    INST_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid("t6");
      chk("t6_pc", INST_PC, 32'(4 * i));
      chk("t6_err", 32'(INST_ERR), 32'(i == 2));
      @(negedge CLK);
    end
    repeat (20) @(negedge CLK);
    chk("t6_ar_still_halt", 32'(ar_cnt - n0), 32'd1);
    chk("t6_empty", 32'(INST_VALID), 32'd0);
    err_beat = -1;
    jump(32'h0);
    wait_ar(n0 + 2, "t6");
    chk("t6_resume_addr", last_addr, 32'h0);
`else
    // Error responses are ignored in this build.
    do_reset(0, 2, 1'b0);
    n0 = ar_cnt;
    repeat (60) @(negedge CLK);
    chk("t6_ar_cnt", 32'(ar_cnt - n0), 32'd2);
    INST_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid("t6");
      chk("t6_pc", INST_PC, 32'(4 * i));
      chk("t6_err", 32'(INST_ERR), 32'd0);
      @(negedge CLK);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
